// File: rtl/matrix_rx.sv
// matrix_rx: oversampling receiver for LED matrix driver lines (SDO/DCLK/LE/GCLK/A-D) used by the loopback self-test.
// Optional 2-sample majority glitch filter on every synchronised line: define MATRIX_RX_GLITCH_FILTER_EN.
module matrix_rx #(
  parameter int CHAIN_BITS = 48,
  parameter int BITCNT_W   = 8,
  parameter int GCLK_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sdo,
  input  logic                  dclk,
  input  logic                  le,
  input  logic                  gclk,
  input  logic                  a,
  input  logic                  b,
  input  logic                  c,
  input  logic                  d,
  output logic                  latch_valid,
  output logic [CHAIN_BITS-1:0] latch_data,
  output logic [3:0]            latch_row,
  output logic [BITCNT_W-1:0]   latch_bits,
  output logic                  latch_err,
  output logic                  row_done,
  output logic [3:0]            row_id,
  output logic [GCLK_CNT_W-1:0] row_gclks,
  output logic                  frame_done
);

  localparam int SDO_I  = 0;
  localparam int DCLK_I = 1;
  localparam int LE_I   = 2;
  localparam int GCLK_I = 3;

  logic [7:0] raw;
  logic [7:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [7:0] lvl, hist;

  assign raw = {d, c, b, a, gclk, le, dclk, sdo};

  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

`ifdef MATRIX_RX_GLITCH_FILTER_EN
  // Majority of (s2, s3, previous accepted level): a level is taken only once s2 and s3 agree.
  logic [7:0] filt_q, filt_d;

  always_comb filt_d = (s2_q & s3_q) | (filt_q & (s2_q | s3_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) filt_q <= '0;
    else      filt_q <= filt_d;
  end

  assign lvl  = filt_d;
  assign hist = filt_q;
`else
  assign lvl  = s2_q;
  assign hist = s3_q;
`endif

  logic unused_hist;
  assign unused_hist = ^{hist[7:4], hist[SDO_I]};

  logic       dclk_rise, le_rise, gclk_rise, sdo_lvl;
  logic [3:0] row_in;

  assign dclk_rise = lvl[DCLK_I] & ~hist[DCLK_I];
  assign le_rise   = lvl[LE_I]   & ~hist[LE_I];
  assign gclk_rise = lvl[GCLK_I] & ~hist[GCLK_I];
  assign sdo_lvl   = lvl[SDO_I];
  assign row_in    = lvl[7:4];

  logic [CHAIN_BITS-1:0] chain_q, chain_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic                  latch_valid_q, latch_valid_d;
  logic [CHAIN_BITS-1:0] latch_data_q, latch_data_d;
  logic [3:0]            latch_row_q, latch_row_d;
  logic [BITCNT_W-1:0]   latch_bits_q, latch_bits_d;
  logic                  latch_err_q, latch_err_d;

  // A coincident DCLK edge shifts first so the latch sees the new bit and its count.
  always_comb begin
    chain_d       = chain_q;
    bitcnt_d      = bitcnt_q;
    latch_valid_d = 1'b0;
    latch_data_d  = latch_data_q;
    latch_row_d   = latch_row_q;
    latch_bits_d  = latch_bits_q;
    latch_err_d   = latch_err_q;
    if (dclk_rise) begin
      chain_d = {chain_q[CHAIN_BITS-2:0], sdo_lvl};
      if (bitcnt_q != '1) bitcnt_d = bitcnt_q + BITCNT_W'(1);
    end
    if (le_rise) begin
      latch_valid_d = 1'b1;
      latch_data_d  = chain_d;
      latch_row_d   = row_in;
      latch_bits_d  = bitcnt_d;
      latch_err_d   = 32'(bitcnt_d) != 32'(CHAIN_BITS);
      bitcnt_d      = '0;
    end
  end

  logic [3:0]            cur_row_q, cur_row_d;
  logic [GCLK_CNT_W-1:0] gcnt_q, gcnt_d;
  logic                  row_done_q, row_done_d;
  logic [3:0]            row_id_q, row_id_d;
  logic [GCLK_CNT_W-1:0] row_gclks_q, row_gclks_d;
  logic                  frame_done_q, frame_done_d;

  // A GCLK edge coincident with a row change belongs to the new row.
  always_comb begin
    cur_row_d    = cur_row_q;
    gcnt_d       = gcnt_q;
    row_done_d   = 1'b0;
    row_id_d     = row_id_q;
    row_gclks_d  = row_gclks_q;
    frame_done_d = 1'b0;
    if (gclk_rise && (gcnt_q != '1)) gcnt_d = gcnt_q + GCLK_CNT_W'(1);
    if (row_in != cur_row_q) begin
      row_done_d   = 1'b1;
      row_id_d     = cur_row_q;
      row_gclks_d  = gcnt_q;
      frame_done_d = (cur_row_q == 4'd15) && (row_in == 4'd0);
      cur_row_d    = row_in;
      gcnt_d       = gclk_rise ? GCLK_CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_q       <= '0;
      bitcnt_q      <= '0;
      latch_valid_q <= 1'b0;
      latch_data_q  <= '0;
      latch_row_q   <= '0;
      latch_bits_q  <= '0;
      latch_err_q   <= 1'b0;
      cur_row_q     <= '0;
      gcnt_q        <= '0;
      row_done_q    <= 1'b0;
      row_id_q      <= '0;
      row_gclks_q   <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      chain_q       <= chain_d;
      bitcnt_q      <= bitcnt_d;
      latch_valid_q <= latch_valid_d;
      latch_data_q  <= latch_data_d;
      latch_row_q   <= latch_row_d;
      latch_bits_q  <= latch_bits_d;
      latch_err_q   <= latch_err_d;
      cur_row_q     <= cur_row_d;
      gcnt_q        <= gcnt_d;
      row_done_q    <= row_done_d;
      row_id_q      <= row_id_d;
      row_gclks_q   <= row_gclks_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign latch_valid = latch_valid_q;
  assign latch_data  = latch_data_q;
  assign latch_row   = latch_row_q;
  assign latch_bits  = latch_bits_q;
  assign latch_err   = latch_err_q;
  assign row_done    = row_done_q;
  assign row_id      = row_id_q;
  assign row_gclks   = row_gclks_q;
  assign frame_done  = frame_done_q;

endmodule

// File: doc/matrix_rx.md
Name: matrix_rx

Overview:
- Panel-side receiver for the LED matrix driver interface: SDO, DCLK, LE, GCLK and the A/B/C/D row select.
- Captures what a matrix driver actually transmits, for the hardware loopback self-test. A panel header output is wired back into FPGA inputs.
- Oversamples all interface lines in the system clock domain and reconstructs the shifted chain word, the latched row address and the per-row GCLK count.
- Results are presented as single-cycle strobes to the self-test checker.

Parameters:
- CHAIN_BITS, 48: length of the emulated driver shift chain (3 drivers x 16 channels).
- BITCNT_W, 8: width of the DCLK-per-latch counter; saturates.
- GCLK_CNT_W, 16: width of the GCLK-per-row counter; saturates.

Ports:
- clk  input  1  system clock (HFOSC, 48 MHz).
- rst  input  1  asynchronous active-low reset; 0 = reset.
- sdo  input  1  serial data from driver, asynchronous.
- dclk  input  1  data clock from driver, asynchronous.
- le  input  1  latch enable from driver, asynchronous.
- gclk  input  1  greyscale clock from driver, asynchronous.
- a, b, c, d  input  1 each  row select; row = {d,c,b,a}.
- latch_valid  output  1  one-cycle strobe: new latch captured.
- latch_data  output  CHAIN_BITS  chain contents at LE; bit 0 = last bit shifted.
- latch_row  output  4  row address sampled at LE.
- latch_bits  output  BITCNT_W  DCLK edges since previous LE.
- latch_err  output  1  latch_bits != CHAIN_BITS; qualified by latch_valid.
- row_done  output  1  one-cycle strobe: row address changed.
- row_id  output  4  row that just ended.
- row_gclks  output  GCLK_CNT_W  GCLK rising edges seen while row_id was selected.
- frame_done  output  1  one-cycle strobe coincident with row_done when the row changes 15 -> 0.

Behaviour:
- Synchronisation:
  - All eight inputs pass through 2-FF synchronisers (s2) plus one history register (s3).
  - A rising edge is s2 & ~s3.
  - Inputs must hold each level >= 2 clk cycles. Narrower pulses may be missed; missed pulses are not flagged.
- Shift chain:
  - On a DCLK rising edge, the chain shifts left by one with s2 of sdo entering bit 0.
  - The bit counter increments and saturates at 2^BITCNT_W-1.
- Latch:
  - On an LE rising edge, in the next cycle:
    - latch_data <= chain and latch_row <= {d,c,b,a} (s2).
    - latch_bits <= counter.
    - latch_err is set per its port definition.
    - latch_valid = 1 for exactly one cycle.
  - The counter clears; the chain is not cleared.
- DCLK and LE edges in the same cycle: the shift happens first, and the latch includes the new bit and the count including it.
- Row tracker:
  - Holds cur_row and a GCLK counter that saturates at 2^GCLK_CNT_W-1.
  - On a GCLK rising edge, the counter increments.
  - When s2 row != cur_row, in the next cycle:
    - row_done = 1, row_id = cur_row, row_gclks = counter.
    - frame_done = 1 if cur_row = 15 and the new row = 0.
    - cur_row <= new row.
    - The counter restarts at 1 if a GCLK edge coincides with the change, else 0.
- Row bits change in the same cycle as each other: they are treated as one transition. Skew between A-D lines of >= 1 clk cycle produces intermediate row_done events; this is accepted.
- Outputs:
  - Data outputs hold their value until the next strobe.
  - Strobes are registered; latch_valid and row_done may assert in the same cycle.
- Reset (async assert, sync deassert by the reset synchroniser upstream):
  - All synchroniser and history flops go to 0, so the first high sample after reset counts as a rising edge.
  - Chain, counters, cur_row, all outputs and all strobes go to 0.
  - Reset mid-shift discards the partial word. No strobe fires on reset release.
- No backpressure: the consumer must accept strobes in the cycle they are given.

Optional Feature:
- MATRIX_RX_GLITCH_FILTER_EN
  - Defined: each synchronised input passes a 2-sample majority filter. A new level is accepted only after 2 consecutive equal s2 samples.
  - Consequences: latency +1 cycle; minimum pulse width becomes 3 clk cycles; 1-cycle glitches are ignored.
  - Undefined: no filter; timing as above.

Test Plan:
- Reset: hold rst=0, toggle every input -> all outputs 0, no strobes. Release and stay idle 100 cycles -> no strobes.
- Nominal latch: 48 DCLK pulses (4 high / 4 low cycles) carrying 0xA5A5_0F0F_F00F MSB-first, then row = 5 and an LE pulse -> one latch_valid with latch_data = 0xA5A5_0F0F_F00F, latch_row = 5, latch_bits = 48, latch_err = 0.
- Short chain and coincidence: 47 DCLK pulses, then LE -> latch_bits = 47, latch_err = 1. Repeat with the 48th DCLK rising in the same clk cycle as LE -> latch_bits = 48, latch_err = 0, and the final bit present.
- Row scan: row 0..15 then 0, with 100 GCLK pulses per row -> 16 row_done strobes with row_id 0..15 and row_gclks = 100; frame_done only on the 15 -> 0 strobe.
- Saturation: with BITCNT_W=4, 20 DCLK pulses then LE -> latch_bits = 15, latch_err = 1.
- Glitch (both builds): a 1-cycle DCLK pulse. With MATRIX_RX_GLITCH_FILTER_EN -> no shift. Without it -> shift may occur. The bench checks the filtered build strictly and skips the check in the unfiltered build.
